// File: rtl/rng_share_arb_if.sv
// Consumer and RNG-side signals of the shared RNG arbiter, bundled as one interface.
// The arbiter binds to the slave modport; the environment drives the master side.
interface rng_share_arb_if #(
  parameter int NREQ = 3,
  parameter int W    = 96
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    rd_data;
  logic            rng_start;
  logic            rng_finish;
  logic [W-1:0]    rng_data;
  logic            busy;
  logic            err;

  modport slave (
    input  req, lock, rng_finish, rng_data,
    output gnt, rd_data, rng_start, busy, err
  );

  modport master (
    output req, lock, rng_finish, rng_data,
    input  gnt, rd_data, rng_start, busy, err
  );
endinterface

// File: rtl/rng_share_arb.sv
// Round-robin arbiter sharing one RNG core between NREQ consumers, keeping one
// prefetched word buffered so a grant is served from the buffer while the RNG refills.
module rng_share_arb #(
  parameter int NREQ = 3,
  parameter int W    = 96
) (
  input  logic          clk,
  input  logic          rst,
  rng_share_arb_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [W-1:0]     buf_q;
  logic [NREQ-1:0]  gnt_q;
  logic [W-1:0]     rd_data_q;
  logic             rng_start_q;
  logic             busy_q;
  logic             err_q;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] ptr_d;
  logic [NREQ-1:0]  gnt_d;

  // Search starts at ptr and wraps explicitly, so NREQ need not be a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int unsigned      idx;
      logic [PTR_W-1:0] cand;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PTR_W'(idx);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A locked winner keeps priority for its next request; otherwise advance past it.
  always_comb begin
    ptr_d = '0;
    if (bus.lock[win_idx]) begin
      ptr_d = win_idx;
    end else if (win_idx == LAST_IDX) begin
      ptr_d = '0;
    end else begin
      ptr_d = PTR_W'(win_idx + 1'b1);
    end
  end

  always_comb begin
    gnt_d          = '0;
    gnt_d[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      ptr_q       <= '0;
      buf_q       <= '0;
      gnt_q       <= '0;
      rd_data_q   <= '0;
      rng_start_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rng_start_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q     <= FILL;
          rng_start_q <= 1'b1;
          if (bus.rng_finish) err_q <= 1'b1;
        end
        FILL: begin
          if (bus.rng_finish) begin
            buf_q   <= bus.rng_data;
            state_q <= FULL;
            busy_q  <= 1'b0;
          end
        end
        FULL: begin
          // A finish here has no run behind it: flag it and drop the word.
          if (bus.rng_finish) err_q <= 1'b1;
          if (win_found) begin
            gnt_q       <= gnt_d;
            rd_data_q   <= buf_q;
            rng_start_q <= 1'b1;
            ptr_q       <= ptr_d;
            state_q     <= FILL;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rng_start = rng_start_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_rng_share_arb.sv
// Directed bench for rng_share_arb with an RNG model of fixed latency L that
// returns a distinct, predictable word for every run.
module tb_rng_share_arb;

  localparam int NREQ = 3;
  localparam int W    = 96;
  localparam int L    = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         model_fin;
  logic [W-1:0] model_data;
  logic         inj_fin;
  logic [W-1:0] inj_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_g = 0;
  int run    = 0;

  rng_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  assign bus.rng_finish = model_fin | inj_fin;
  assign bus.rng_data   = inj_fin ? inj_data : model_data;

  rng_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input int n);
    logic [31:0] t;
    if (n == 0) return {12{8'hA5}};
    t = 32'hC0DE0000 + 32'(n);
    return {t, ~t, t};
  endfunction

  // RNG model: a start seen at edge s yields a finish sampled at edge s+L.
  initial begin
    model_fin  = 1'b0;
    model_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rng_start) begin
        for (int i = 0; i < L; i++) @(negedge clk);
        model_fin  = 1'b1;
        model_data = word_of(run);
        run++;
        @(negedge clk);
        model_fin = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [NREQ-1:0] eg,
                          input logic [W-1:0] ew, input bit sp);
    int n;
    tick();
    n = 1;
    while (bus.gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    chkw({tag, ".data"}, bus.rd_data, ew);
    chk({tag, ".start"}, 32'(bus.rng_start), 32'd1);
    if (sp) chk({tag, ".gap"}, 32'(cyc - last_g), 32'(L + 2));
    last_g = cyc;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
    chkw({tag, ".rd"}, bus.rd_data, '0);
    chk({tag, ".start"}, 32'(bus.rng_start), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] ord3 [6];
    int n_start;
    int fall;
    int n;
    ord3 = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    // 1: boot and idle
    rst      = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    inj_fin  = 1'b0;
    inj_data = '0;
    repeat (3) tick();
    chk_reset("t1.rst");
    rst     = 1'b0;
    n_start = 0;
    fall    = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.rng_start) n_start++;
      if (fall == 0 && !bus.busy) fall = i;
    end
    chk("t1.starts", 32'(n_start), 32'd1);
    chk("t1.busyfall", 32'(fall), 32'(L + 2));
    chk("t1.gnt", 32'(bus.gnt), 32'd0);

    // 2: single grant
    bus.req = 3'b010;
    wait_gnt("t2", 3'b010, word_of(0), 1'b0);
    bus.req = '0;
    tick();
    chk("t2.pulse", 32'(bus.gnt), 32'd0);
    chkw("t2.hold", bus.rd_data, word_of(0));

    // 3: round-robin from ptr=2 with all requesting
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) wait_gnt("t3", ord3[k], word_of(1 + k), 1'b1);

    // 4: burst lock on requester 2
    bus.req  = 3'b101;
    bus.lock = 3'b100;
    for (int k = 0; k < 3; k++) wait_gnt("t4.lock", 3'b100, word_of(7 + k), 1'b1);
    bus.lock = '0;
    wait_gnt("t4.rel2", 3'b100, word_of(10), 1'b1);
    wait_gnt("t4.rel0", 3'b001, word_of(11), 1'b1);
    bus.req = '0;

    // 5: stray finish while FULL
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk("t5.full", 32'(bus.busy), 32'd0);
    inj_data = {12{8'h3C}};
    inj_fin  = 1'b1;
    tick();
    inj_fin = 1'b0;
    chk("t5.err", 32'(bus.err), 32'd1);
    chk("t5.state", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("t5.sticky", 32'(bus.err), 32'd1);
    chk("t5.nostart", 32'(bus.rng_start), 32'd0);
    bus.req = 3'b001;
    wait_gnt("t5", 3'b001, word_of(12), 1'b0);
    chk("t5.err2", 32'(bus.err), 32'd1);
    bus.req = '0;

    // 6: reset two cycles after a grant, while the run is outstanding
    tick();
    rst = 1'b1;
    tick();
    chk_reset("t6.rst");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("t6.restart", 32'(bus.rng_start), 32'd1);
    chk("t6.busy", 32'(bus.busy), 32'd1);
    bus.req = 3'b100;
    wait_gnt("t6", 3'b100, word_of(14), 1'b0);
    chk("t6.err", 32'(bus.err), 32'd0);
    bus.req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
